// File: rtl/bank_request_tracker.sv
// -----------------------------------------------------------------------------
// bank_request_tracker
//
// Per-bank request tracker placed between the bank scheduler's request and
// response ports and the response statistics logger.
//
// Each accepted request is tagged with a sequential request ID and the
// globalCycle value at which it was issued. The tag is stored in a DEPTH-entry
// FIFO. Responses come back in request order. Each response pops the FIFO head
// and, one cycle later, produces a registered stat record with these fields:
// id, address, type, response cycle and latency. The block also owns the
// bank's free-running globalCycle counter.
//
// Parameters
//   RANK, BANKGROUP, BANK : bank coordinates. They identify the instance only.
//   DEPTH                 : maximum number of outstanding requests
//                           (must be a power of 2 and >= 2)
//   ADDR_W                : request address width
//   CYCLE_INIT, ID_INIT   : values loaded into globalCycle and the ID counter
//                           while reset is asserted. Both default to 0.
//                           Non-zero values let an instance start close to a
//                           counter wrap point.
//
// Ports
//   clk, reset (async, active low)
//   req_valid / req_ready / req_rd_en / req_wr_en / req_addr : request side
//   resp_valid / resp_ready                                  : response side
//   stat_*            : completed-request record; valid while stat_fire=1,
//                       held otherwise
//   stat_max_latency  : largest latency seen since reset
//   globalCycle       : free-running cycle counter
//   outstanding       : number of entries currently tracked
//   orphan_err        : sticky; a response arrived with nothing tracked
//   cmd_err           : sticky; an accepted request had rd_en == wr_en
// -----------------------------------------------------------------------------
module bank_request_tracker #(
  parameter int unsigned RANK       = 0,
  parameter int unsigned BANKGROUP  = 0,
  parameter int unsigned BANK       = 0,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_W     = 32,
  parameter logic [63:0] CYCLE_INIT = 64'd0,
  parameter logic [31:0] ID_INIT    = 32'd0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_rd_en,
  input  logic                       req_wr_en,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic                       resp_valid,
  input  logic                       resp_ready,
  output logic                       stat_fire,
  output logic [31:0]                stat_request_id,
  output logic [ADDR_W-1:0]          stat_addr,
  output logic                       stat_rd_en,
  output logic                       stat_wr_en,
  output logic [63:0]                stat_cycle,
  output logic [63:0]                stat_latency,
  output logic [63:0]                stat_max_latency,
  output logic [63:0]                globalCycle,
  output logic [$clog2(DEPTH):0]     outstanding,
  output logic                       orphan_err,
  output logic                       cmd_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // The bank coordinates only identify the instance. No datapath logic uses them.
  localparam logic [31:0] BANK_TAG = RANK ^ BANKGROUP ^ BANK;
  logic [31:0] unused_bank_tag;
  assign unused_bank_tag = BANK_TAG;

  // ---------------------------------------------------------------------------
  // Tag FIFO storage. Entries are not reset: the pointers and the count decide
  // which entries are meaningful.
  // ---------------------------------------------------------------------------
  logic [31:0]       fifo_id_q    [DEPTH];
  logic [ADDR_W-1:0] fifo_addr_q  [DEPTH];
  logic              fifo_rd_q    [DEPTH];
  logic              fifo_wr_q    [DEPTH];
  logic [63:0]       fifo_cycle_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Control and statistic state
  // ---------------------------------------------------------------------------
  logic [63:0]       global_cycle_q, global_cycle_d;
  logic [31:0]       next_id_q, next_id_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              req_ready_q, req_ready_d;
  logic              orphan_err_q, orphan_err_d;
  logic              cmd_err_q, cmd_err_d;

  logic              stat_fire_q, stat_fire_d;
  logic [31:0]       stat_id_q, stat_id_d;
  logic [ADDR_W-1:0] stat_addr_q, stat_addr_d;
  logic              stat_rd_q, stat_rd_d;
  logic              stat_wr_q, stat_wr_d;
  logic [63:0]       stat_cycle_q, stat_cycle_d;
  logic [63:0]       stat_latency_q, stat_latency_d;
  logic [63:0]       stat_max_q, stat_max_d;

  logic              accept;
  logic              resp_fire;
  logic              pop;
  logic              orphan;
  logic [63:0]       head_latency;

  always_comb begin
    accept    = req_valid & req_ready_q;
    resp_fire = resp_valid & resp_ready;
    // A response that meets an empty FIFO is orphaned, even if a request is
    // pushed in the same cycle. That new entry belongs to a later response.
    pop       = resp_fire & (count_q != '0);
    orphan    = resp_fire & (count_q == '0);

    // Modular subtraction, so the latency stays correct across a globalCycle wrap.
    head_latency = global_cycle_q - fifo_cycle_q[rd_ptr_q];

    global_cycle_d = global_cycle_q + 64'd1;
    next_id_d      = accept ? next_id_q + 32'd1 : next_id_q;
    wr_ptr_d       = accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d       = pop    ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Registered from the next count, so req_valid has no combinational path
    // to req_ready.
    req_ready_d  = (count_d < DEPTH_C);

    orphan_err_d = orphan_err_q | orphan;
    cmd_err_d    = cmd_err_q | (accept & (req_rd_en == req_wr_en));

    stat_fire_d    = pop;
    stat_id_d      = stat_id_q;
    stat_addr_d    = stat_addr_q;
    stat_rd_d      = stat_rd_q;
    stat_wr_d      = stat_wr_q;
    stat_cycle_d   = stat_cycle_q;
    stat_latency_d = stat_latency_q;
    stat_max_d     = stat_max_q;
    if (pop) begin
      stat_id_d      = fifo_id_q[rd_ptr_q];
      stat_addr_d    = fifo_addr_q[rd_ptr_q];
      stat_rd_d      = fifo_rd_q[rd_ptr_q];
      stat_wr_d      = fifo_wr_q[rd_ptr_q];
      stat_cycle_d   = global_cycle_q;
      stat_latency_d = head_latency;
      if (head_latency > stat_max_q) begin
        stat_max_d = head_latency;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_id_q[wr_ptr_q]    <= next_id_q;
      fifo_addr_q[wr_ptr_q]  <= req_addr;
      fifo_rd_q[wr_ptr_q]    <= req_rd_en;
      fifo_wr_q[wr_ptr_q]    <= req_wr_en;
      fifo_cycle_q[wr_ptr_q] <= global_cycle_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      global_cycle_q <= CYCLE_INIT;
      next_id_q      <= ID_INIT;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      req_ready_q    <= 1'b0;
      orphan_err_q   <= 1'b0;
      cmd_err_q      <= 1'b0;
      stat_fire_q    <= 1'b0;
      stat_id_q      <= '0;
      stat_addr_q    <= '0;
      stat_rd_q      <= 1'b0;
      stat_wr_q      <= 1'b0;
      stat_cycle_q   <= '0;
      stat_latency_q <= '0;
      stat_max_q     <= '0;
    end else begin
      global_cycle_q <= global_cycle_d;
      next_id_q      <= next_id_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      req_ready_q    <= req_ready_d;
      orphan_err_q   <= orphan_err_d;
      cmd_err_q      <= cmd_err_d;
      stat_fire_q    <= stat_fire_d;
      stat_id_q      <= stat_id_d;
      stat_addr_q    <= stat_addr_d;
      stat_rd_q      <= stat_rd_d;
      stat_wr_q      <= stat_wr_d;
      stat_cycle_q   <= stat_cycle_d;
      stat_latency_q <= stat_latency_d;
      stat_max_q     <= stat_max_d;
    end
  end

  assign req_ready        = req_ready_q;
  assign stat_fire        = stat_fire_q;
  assign stat_request_id  = stat_id_q;
  assign stat_addr        = stat_addr_q;
  assign stat_rd_en       = stat_rd_q;
  assign stat_wr_en       = stat_wr_q;
  assign stat_cycle       = stat_cycle_q;
  assign stat_latency     = stat_latency_q;
  assign stat_max_latency = stat_max_q;
  assign globalCycle      = global_cycle_q;
  assign outstanding      = count_q;
  assign orphan_err       = orphan_err_q;
  assign cmd_err          = cmd_err_q;

endmodule

// File: tb/tb_bank_request_tracker.sv
module tb_bank_request_tracker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  // main instance (default parameters)
  logic        req_valid = 0, req_rd_en = 0, req_wr_en = 0;
  logic [31:0] req_addr = '0;
  logic        resp_valid = 0, resp_ready = 0;
  logic        req_ready, stat_fire, stat_rd_en, stat_wr_en, orphan_err, cmd_err;
  logic [31:0] stat_request_id, stat_addr;
  logic [63:0] stat_cycle, stat_latency, stat_max_latency, gc;
  logic [3:0]  outstanding;

  // wrap instance (counters preloaded close to their wrap points)
  logic        w_req_valid = 0, w_req_rd_en = 0, w_req_wr_en = 0;
  logic [31:0] w_req_addr = '0;
  logic        w_resp_valid = 0, w_resp_ready = 0;
  logic        w_req_ready, w_stat_fire, w_stat_rd_en, w_stat_wr_en, w_orphan_err, w_cmd_err;
  logic [31:0] w_stat_request_id, w_stat_addr;
  logic [63:0] w_stat_cycle, w_stat_latency, w_stat_max_latency, w_gc;
  logic [3:0]  w_outstanding;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bank_request_tracker #(.DEPTH(8), .ADDR_W(32)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rd_en(req_rd_en),
    .req_wr_en(req_wr_en), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .stat_fire(stat_fire), .stat_request_id(stat_request_id), .stat_addr(stat_addr),
    .stat_rd_en(stat_rd_en), .stat_wr_en(stat_wr_en), .stat_cycle(stat_cycle),
    .stat_latency(stat_latency), .stat_max_latency(stat_max_latency),
    .globalCycle(gc), .outstanding(outstanding),
    .orphan_err(orphan_err), .cmd_err(cmd_err)
  );

  bank_request_tracker #(
    .DEPTH(8), .ADDR_W(32),
    .CYCLE_INIT(64'hFFFF_FFFF_FFFF_FFFA), .ID_INIT(32'hFFFF_FFFF)
  ) u_wrap (
    .clk(clk), .reset(reset),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_rd_en(w_req_rd_en),
    .req_wr_en(w_req_wr_en), .req_addr(w_req_addr),
    .resp_valid(w_resp_valid), .resp_ready(w_resp_ready),
    .stat_fire(w_stat_fire), .stat_request_id(w_stat_request_id), .stat_addr(w_stat_addr),
    .stat_rd_en(w_stat_rd_en), .stat_wr_en(w_stat_wr_en), .stat_cycle(w_stat_cycle),
    .stat_latency(w_stat_latency), .stat_max_latency(w_stat_max_latency),
    .globalCycle(w_gc), .outstanding(w_outstanding),
    .orphan_err(w_orphan_err), .cmd_err(w_cmd_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req_valid = 0; req_rd_en = 0; req_wr_en = 0; req_addr = '0;
    resp_valid = 0; resp_ready = 0;
    w_req_valid = 0; w_req_rd_en = 0; w_req_wr_en = 0; w_req_addr = '0;
    w_resp_valid = 0; w_resp_ready = 0;
    #2 reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_id;

    // ---------------- reset state and release ----------------
    #2 reset = 1'b0;
    #1;
    chk("rst_gc", gc, 64'd0);
    chk("rst_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_outst", {60'd0, outstanding}, 64'd0);
    chk("rst_flags", {62'd0, orphan_err, cmd_err}, 64'd0);
    chk("rst_fire", {63'd0, stat_fire}, 64'd0);
    repeat (2) tick();
    reset = 1'b1;
    chk("rel_ready0", {63'd0, req_ready}, 64'd0);
    tick();
    chk("rel_gc1", gc, 64'd1);
    chk("rel_ready1", {63'd0, req_ready}, 64'd1);
    tick();
    chk("rel_gc2", gc, 64'd2);

    // ---------------- single read ----------------
    for (int n = 0; n < 40 && gc != 64'd10; n++) tick();
    chk("wait_gc10", gc, 64'd10);
    req_valid = 1; req_rd_en = 1; req_wr_en = 0; req_addr = 32'h40;
    tick();
    req_valid = 0; req_rd_en = 0;
    chk("rd_outst", {60'd0, outstanding}, 64'd1);
    for (int n = 0; n < 40 && gc != 64'd17; n++) tick();
    chk("wait_gc17", gc, 64'd17);
    resp_valid = 1; resp_ready = 1;
    tick();
    resp_valid = 0;
    chk("rd_fire", {63'd0, stat_fire}, 64'd1);
    chk("rd_id", {32'd0, stat_request_id}, 64'd0);
    chk("rd_addr", {32'd0, stat_addr}, 64'h40);
    chk("rd_type", {62'd0, stat_rd_en, stat_wr_en}, 64'b10);
    chk("rd_cycle", stat_cycle, 64'd17);
    chk("rd_lat", stat_latency, 64'd7);
    chk("rd_max", stat_max_latency, 64'd7);
    tick();
    chk("rd_fire_off", {63'd0, stat_fire}, 64'd0);
    chk("rd_hold", stat_cycle, 64'd17);
    chk("rd_outst0", {60'd0, outstanding}, 64'd0);

    // ---------------- fill, full, push+pop, in-order drain ----------------
    apply_reset();
    tick();
    req_valid = 1;
    for (int i = 0; i < 8; i++) begin
      req_addr = 32'h100 + 32'(i * 4);
      req_rd_en = (i % 2 == 0);
      req_wr_en = (i % 2 != 0);
      tick();
    end
    chk("full_outst", {60'd0, outstanding}, 64'd8);
    chk("full_ready", {63'd0, req_ready}, 64'd0);
    req_addr = 32'hDEAD;
    tick();
    chk("full_nopush", {60'd0, outstanding}, 64'd8);
    req_valid = 0;
    resp_valid = 1; resp_ready = 1;
    tick();
    chk("pop0_id", {32'd0, stat_request_id}, 64'd0);
    chk("pop0_addr", {32'd0, stat_addr}, 64'h100);
    chk("pop0_outst", {60'd0, outstanding}, 64'd7);
    chk("pop0_ready", {63'd0, req_ready}, 64'd1);
    req_valid = 1; req_addr = 32'h200; req_rd_en = 1; req_wr_en = 0;
    tick();
    req_valid = 0;
    chk("pp_id", {32'd0, stat_request_id}, 64'd1);
    chk("pp_type", {62'd0, stat_rd_en, stat_wr_en}, 64'b01);
    chk("pp_outst", {60'd0, outstanding}, 64'd7);
    exp_id = 32'd2;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("drain_fire", {63'd0, stat_fire}, 64'd1);
      chk("drain_id", {32'd0, stat_request_id}, {32'd0, exp_id});
      exp_id++;
    end
    chk("drain_outst", {60'd0, outstanding}, 64'd0);
    chk("drain_addr8", {32'd0, stat_addr}, 64'h200);

    // ---------------- orphan response ----------------
    tick();
    chk("orph_fire", {63'd0, stat_fire}, 64'd0);
    chk("orph_err", {63'd0, orphan_err}, 64'd1);
    chk("orph_outst", {60'd0, outstanding}, 64'd0);
    resp_valid = 0;
    repeat (3) tick();
    chk("orph_sticky", {63'd0, orphan_err}, 64'd1);
    // push into empty with same-cycle response: push lands, no record
    req_valid = 1; req_addr = 32'h300; req_rd_en = 1; req_wr_en = 0;
    resp_valid = 1;
    tick();
    req_valid = 0; resp_valid = 0;
    chk("orph_push_outst", {60'd0, outstanding}, 64'd1);
    chk("orph_push_fire", {63'd0, stat_fire}, 64'd0);
    resp_valid = 1;
    tick();
    resp_valid = 0;
    chk("orph_push_id", {32'd0, stat_request_id}, 64'd9);
    chk("orph_push_addr", {32'd0, stat_addr}, 64'h300);

    // ---------------- cmd_err ----------------
    apply_reset();
    chk("clr_orphan", {63'd0, orphan_err}, 64'd0);
    tick();
    req_valid = 1; req_addr = 32'h55; req_rd_en = 1; req_wr_en = 1;
    tick();
    req_valid = 0; req_rd_en = 0; req_wr_en = 0;
    chk("cmd_err", {63'd0, cmd_err}, 64'd1);
    resp_valid = 1; resp_ready = 1;
    tick();
    resp_valid = 0;
    chk("cmd_fire", {63'd0, stat_fire}, 64'd1);
    chk("cmd_type", {62'd0, stat_rd_en, stat_wr_en}, 64'b11);
    chk("cmd_lat", stat_latency, 64'd1);
    tick();
    chk("cmd_sticky", {63'd0, cmd_err}, 64'd1);

    // ---------------- async reset mid-burst ----------------
    req_valid = 1; req_rd_en = 1; req_wr_en = 0;
    repeat (3) tick();
    req_valid = 0;
    resp_valid = 1;
    tick();
    chk("burst_fire", {63'd0, stat_fire}, 64'd1);
    #3 reset = 1'b0;
    #1;
    chk("mid_outst", {60'd0, outstanding}, 64'd0);
    chk("mid_fire", {63'd0, stat_fire}, 64'd0);
    chk("mid_ready", {63'd0, req_ready}, 64'd0);
    chk("mid_cmd", {63'd0, cmd_err}, 64'd0);
    repeat (2) tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_fire", {63'd0, stat_fire}, 64'd0);
    end
    resp_valid = 0;

    // ---------------- globalCycle and ID wrap ----------------
    apply_reset();
    chk("w_init_gc", w_gc, 64'hFFFF_FFFF_FFFF_FFFA);
    for (int n = 0; n < 20 && w_gc != 64'hFFFF_FFFF_FFFF_FFFD; n++) tick();
    chk("w_wait", w_gc, 64'hFFFF_FFFF_FFFF_FFFD);
    w_req_valid = 1; w_req_addr = 32'h80; w_req_rd_en = 1; w_req_wr_en = 0;
    tick();
    w_req_addr = 32'h84; w_req_rd_en = 0; w_req_wr_en = 1;
    tick();
    w_req_valid = 0; w_req_wr_en = 0;
    chk("w_outst", {60'd0, w_outstanding}, 64'd2);
    tick();
    chk("w_gc_wrap", w_gc, 64'd0);
    repeat (2) tick();
    chk("w_gc2", w_gc, 64'd2);
    w_resp_valid = 1; w_resp_ready = 1;
    tick();
    chk("w_id_max", {32'd0, w_stat_request_id}, 64'hFFFF_FFFF);
    chk("w_cycle", w_stat_cycle, 64'd2);
    chk("w_lat", w_stat_latency, 64'd5);
    chk("w_rd", {62'd0, w_stat_rd_en, w_stat_wr_en}, 64'b10);
    tick();
    w_resp_valid = 0;
    chk("w_id_wrap", {32'd0, w_stat_request_id}, 64'd0);
    chk("w_addr", {32'd0, w_stat_addr}, 64'h84);
    chk("w_lat2", w_stat_latency, 64'd5);
    chk("w_max", w_stat_max_latency, 64'd5);
    chk("w_fire", {63'd0, w_stat_fire}, 64'd1);
    tick();
    chk("w_end", {59'd0, w_outstanding, w_req_ready}, 64'd1);
    chk("w_flags", {62'd0, w_orphan_err, w_cmd_err}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
